// File: rtl/modq_pkg.sv
// Shared constants and types for the Kyber (q=3329) modular arithmetic datapath.
package modq_pkg;
  localparam int unsigned Q  = 3329;
  localparam int unsigned W  = 12;
  localparam int unsigned K  = 26;
  localparam int unsigned MU = 20158;
  localparam int unsigned PW = 2 * W;   // product width
  localparam int unsigned TW = 14;      // partial residue width, holds [0, 3Q)
  localparam int unsigned MW = PW + 15; // p*MU width

  typedef logic [W-1:0]  coeff_t;
  typedef logic [PW-1:0] prod_t;
  typedef logic [TW-1:0] resid_t;

  localparam resid_t Q_T     = resid_t'(Q);
  localparam resid_t TWO_Q_T = resid_t'(2 * Q);

  // Final correction: bring a residue in [0, 3Q) into [0, Q).
  function automatic coeff_t fold_3q(input resid_t t);
    resid_t v;
    if (t >= TWO_Q_T)  v = t - TWO_Q_T;
    else if (t >= Q_T) v = t - Q_T;
    else               v = t;
    return v[W-1:0];
  endfunction
endpackage

// File: rtl/mod_multiplier_barrett_reduce.sv
// Barrett reduction of a 24-bit product mod Q: S2 registers t in [0,3Q), S3 folds and registers r.
module barrett_reduce
  import modq_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  input  prod_t  p,
  output logic   t_valid,
  output logic   out_valid,
  output coeff_t r
);
  logic [MW-1:0]   p_mu;
  logic [MW-K-1:0] qh;
  prod_t           qh_q;
  prod_t           diff;

  resid_t t_q,       t_d;
  logic   t_valid_q, t_valid_d;
  coeff_t r_q,       r_d;
  logic   done_q,    done_d;

  always_comb begin
    p_mu      = MW'(p) * MW'(MU);
    qh        = p_mu[MW-1:K];
    qh_q      = PW'(qh) * PW'(Q);
    diff      = p - qh_q;
    t_d       = diff[TW-1:0];
    t_valid_d = in_valid;
    // r holds its value between results; only a valid S2 word updates it.
    r_d       = t_valid_q ? fold_3q(t_q) : r_q;
    done_d    = t_valid_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q       <= '0;
      t_valid_q <= 1'b0;
      r_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      t_q       <= t_d;
      t_valid_q <= t_valid_d;
      r_q       <= r_d;
      done_q    <= done_d;
    end
  end

  assign t_valid   = t_valid_q;
  assign out_valid = done_q;
  assign r         = r_q;
endmodule

// File: rtl/mod_multiplier.sv
// Modular multiplier r = a*b mod 3329 with 3-cycle latency.
// Define MODMUL_PIPE_EN for a fully pipelined engine (en every cycle, busy tied 0).
module mod_multiplier
  import modq_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  coeff_t a,
  input  coeff_t b,
  output logic   busy,
  output logic   done,
  output coeff_t r
);
  logic   capture;
  coeff_t a_q, a_d;
  coeff_t b_q, b_d;
  logic   cap_q, cap_d;
  prod_t  p_q, p_d;
  logic   p_valid_q, p_valid_d;
  logic   t_valid;

`ifdef MODMUL_PIPE_EN
  assign capture = en;
  assign busy    = 1'b0;
`else
  logic busy_q, busy_d;

  // Busy drops on the same edge that raises done (t_valid is the S2 stage).
  always_comb begin
    busy_d = busy_q;
    if (capture)      busy_d = 1'b1;
    else if (t_valid) busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= busy_d;
  end

  assign capture = en && !busy_q;
  assign busy    = busy_q;
`endif

  // NOTE: every always_comb output gets a value on all paths, so no latch is inferred.
  always_comb begin
    a_d       = capture ? a : a_q;
    b_d       = capture ? b : b_q;
    cap_d     = capture;
    p_d       = PW'(a_q) * PW'(b_q);
    p_valid_d = cap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      cap_q     <= 1'b0;
      p_q       <= '0;
      p_valid_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      cap_q     <= cap_d;
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
    end
  end

  barrett_reduce u_reduce (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (p_valid_q),
    .p         (p_q),
    .t_valid   (t_valid),
    .out_valid (done),
    .r         (r)
  );
endmodule

// File: tb/tb_mod_multiplier.sv
// Self-checking bench for mod_multiplier: directed table, sweeps, random pairs, abort and busy corners.
module tb_mod_multiplier;
  localparam int QM = 3329;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] a = '0;
  logic [11:0] b = '0;
  logic        busy;
  logic        done;
  logic [11:0] r;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int exp_q[$];
  logic prev_done = 1'b0;

  typedef struct {
    int a;
    int b;
    int r;
  } vec_t;
  vec_t vecs[6];

  mod_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .r     (r)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: each done pops the oldest expected result.
  always @(posedge clk) begin
    #1;
    if (done) begin
      done_cnt++;
`ifndef MODMUL_PIPE_EN
      check("done_single_cycle", int'(prev_done), 0);
`endif
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check("result", int'(r), exp_q.pop_front());
      end
    end
    prev_done = done;
  end

  // Start one operation; with timing=1 also verify busy/done against the 3-cycle schedule.
  task automatic run_op(input int av, input int bv, input int expv, input bit timing);
    int waited;
    waited = 0;
    @(negedge clk);
    while (busy && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (busy) check("busy_timeout", 1, 0);
    en = 1'b1;
    a  = 12'(av);
    b  = 12'(bv);
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    en = 1'b0;
    if (timing) begin
`ifndef MODMUL_PIPE_EN
      check("busy_after_capture", int'(busy), 1);
`endif
      repeat (2) begin
        @(posedge clk);
        #1;
        check("done_early", int'(done), 0);
`ifndef MODMUL_PIPE_EN
        check("busy_in_flight", int'(busy), 1);
`endif
      end
      @(posedge clk);
      #1;
      check("done_at_3", int'(done), 1);
      check("busy_clear_at_done", int'(busy), 0);
    end
  endtask

  initial begin
    int cnt0;
    vecs[0] = '{0, 0, 0};
    vecs[1] = '{1, 1, 1};
    vecs[2] = '{3328, 3328, 1};
    vecs[3] = '{3000, 3000, 1713};
    vecs[4] = '{4095, 4095, 852};
    vecs[5] = '{3329, 4095, 0};

    #2;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_r", int'(r), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].r, 1'b1);

`ifndef MODMUL_PIPE_EN
    // en re-pulsed while busy with different operands: must be ignored.
    cnt0 = done_cnt;
    run_op(3, 5, 15, 1'b0);
    @(negedge clk);
    en = 1'b1; a = 12'd7; b = 12'd9;
    @(negedge clk);
    en = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("ignored_en_one_done", done_cnt - cnt0, 1);
`endif

    // Reset one cycle after capture aborts the operation.
    cnt0 = done_cnt;
    run_op(100, 200, 20000 % QM, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_r", int'(r), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check("abort_no_done", done_cnt - cnt0, 0);
    run_op(3000, 3000, 1713, 1'b1);

    // Sweeps across the full residue range and above Q.
    for (int i = 0; i < 3329; i += 7) run_op(i, 3328, (i * 3328) % QM, 1'b0);
    for (int i = 0; i < 4096; i += 13) run_op(4095, i, (4095 * i) % QM, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      int ra, rb;
      ra = int'($urandom_range(4095));
      rb = int'($urandom_range(4095));
      run_op(ra, rb, (ra * rb) % QM, 1'b0);
    end

`ifdef MODMUL_PIPE_EN
    // Back-to-back issue: 10 captures on consecutive edges, 10 in-order results.
    cnt0 = done_cnt;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      en = 1'b1;
      a  = 12'(300 * i + 17);
      b  = 12'(4095 - 211 * i);
      exp_q.push_back(((300 * i + 17) * (4095 - 211 * i)) % QM);
      @(negedge clk);
    end
    en = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("pipe_done_count", done_cnt - cnt0, 10);
`endif

    repeat (8) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
